// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: CPU request/response and data-memory signals of the load/store port.
//   req_*  : one load/store request (valid/ready, we, funct3 op, byte addr, low-aligned wdata, tag)
//   resp_* : completion (valid/ready, extended data, tag, error)
//   mem_*  : memory side (free, rw_flag, word addr, lane-shifted wdata, byte mask, read_valid, rdata)
//   master : the load/store unit; slave : the CPU/memory environment
interface lsu_mem_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_err;
    logic                  mem_free;
    logic [1:0]            mem_rw_flag;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_mask;
    logic                  mem_read_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport master (
        input  req_valid, req_we, req_op, req_addr, req_wdata, req_tag, resp_ready,
               mem_free, mem_read_valid, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_tag, resp_err,
               mem_rw_flag, mem_addr, mem_wdata, mem_mask
    );
    modport slave (
        output req_valid, req_we, req_op, req_addr, req_wdata, req_tag, resp_ready,
               mem_free, mem_read_valid, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_err,
               mem_rw_flag, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator between execute stage and data memory.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : lsu_mem_port_if.master (CPU request/response and memory flag/free/read_valid protocol)
module lsu_mem_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_port_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t                r_state, w_next;
    logic                  r_we;
    logic [2:0]            r_op;
    logic [1:0]            r_lane;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            r_mask;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            w_lane;
    logic                  w_bad;
    logic [3:0]            w_mask;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_sign;
    logic                  w_done;
    logic                  w_tmo;
    assign w_lane = bus.req_addr[1:0];
    // 011 and 11x are not loads or stores; stores have no unsigned variants
    assign w_bad = bus.req_op == 3'b011 || bus.req_op[2:1] == 2'b11 || (bus.req_we && bus.req_op[2])
                || (bus.req_op[1:0] == 2'b01 && bus.req_addr[0])
                || (bus.req_op[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign w_mask = bus.req_op[1:0] == 2'b00 ? 4'b0001 << w_lane
                  : bus.req_op[1:0] == 2'b01 ? 4'b0011 << w_lane : 4'b1111;
    assign w_shifted = bus.mem_rdata >> {r_lane, 3'b000};
    assign w_sign = !r_op[2];
    assign w_ext = r_op[1:0] == 2'b00 ? {{(DATA_WIDTH-8){w_sign & w_shifted[7]}}, w_shifted[7:0]}
                 : r_op[1:0] == 2'b01 ? {{(DATA_WIDTH-16){w_sign & w_shifted[15]}}, w_shifted[15:0]}
                 : w_shifted;
    // stores complete when the memory reports free again, loads on the read pulse
    assign w_done = r_state == WAIT && (r_we ? bus.mem_free : bus.mem_read_valid);
    assign w_tmo  = r_state == WAIT && !w_done && r_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        bus.req_ready   = r_state == IDLE;
        bus.resp_valid  = r_state == DONE;
        bus.resp_data   = r_data;
        bus.resp_tag    = r_tag;
        bus.resp_err    = r_err;
        bus.mem_rw_flag = (r_state == ISSUE && bus.mem_free) ? (r_we ? 2'b01 : 2'b10) : 2'b00;
        bus.mem_addr    = r_addr;
        bus.mem_wdata   = r_wdata;
        bus.mem_mask    = r_mask;
        case (r_state)
            IDLE:    w_next = bus.req_valid ? (w_bad ? DONE : ISSUE) : IDLE;
            ISSUE:   w_next = bus.mem_free ? WAIT : ISSUE;
            WAIT:    w_next = (w_done || w_tmo) ? DONE : WAIT;
            DONE:    w_next = bus.resp_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_op    <= '0;
            r_lane  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            r_tag   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (r_state == IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_op    <= bus.req_op;
                r_lane  <= w_lane;
                r_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                r_wdata <= bus.req_wdata << {w_lane, 3'b000};
                r_mask  <= w_mask;
                r_tag   <= bus.req_tag;
                r_data  <= '0;
                r_err   <= w_bad;
            end
            r_cnt <= r_state == WAIT ? r_cnt + 1'b1 : '0;
            if (w_done) begin
                r_data <= r_we ? '0 : w_ext;
                r_err  <= 1'b0;
            end else if (w_tmo) begin
                r_data <= '0;
                r_err  <= 1'b1;
            end
        end
    end
endmodule
